execute_pipe: RTL and testbench
===============================

// Module: execute_pipe
// PURPOSE
//   Pipelined Y86-64 execute stage: selects ALU operands/function from the E-register fields, computes valE,
//   holds the condition-code register (ZF,SF,OF), evaluates Cnd for jXX/cmovXX and latches results into the
//   M pipeline register with stall/bubble control. Sits between the decode/E register and the memory stage.
//   Also drives the combinational e_valE/e_dstE forwarding path to decode.
// PARAMETERS
//   WIDTH      64      datapath width in bits (valA/valB/valC/valE); must be a multiple of 8, >=16
//   STACK_STEP WIDTH/8 stack-pointer step used by call/push (-STEP) and ret/pop (+STEP)
//   CC_RESET   3'b100  reset value of {ZF,SF,OF}
// PORTS
//   clk       in   1      clock, all state rising-edge
//   rst       in   1      asynchronous reset, active-high
//   E_stat    in   2      status of instruction in E (0 AOK,1 HLT,2 ADR,3 INS)
//   E_icode   in   4      instruction code
//   E_ifun    in   4      function code
//   E_valC    in   WIDTH  constant word
//   E_valA    in   WIDTH  operand A (after forwarding)
//   E_valB    in   WIDTH  operand B (after forwarding)
//   E_dstE    in   4      ALU destination register id (4'hF = none)
//   E_dstM    in   4      memory destination register id
//   m_stat    in   2      status leaving memory stage this cycle
//   W_stat    in   2      status in write-back register
//   M_stall   in   1      hold M register and CC
//   M_bubble  in   1      load nop bubble into M register
//   e_valE    out  WIDTH  combinational ALU result (forwarding)
//   e_dstE    out  4      combinational dstE after cmov squash (forwarding)
//   e_Cnd     out  1      combinational condition result
//   cc        out  3      registered {ZF,SF,OF}
//   M_stat,M_icode,M_Cnd,M_valE,M_valA,M_dstE,M_dstM  out  2/4/1/WIDTH/WIDTH/4/4  M pipeline register
// BEHAVIOUR
//   - Reset (async, rst=1): cc=CC_RESET; M_icode=4'h1 (nop), M_stat=AOK, M_Cnd=0, M_valE=M_valA=0,
//     M_dstE=M_dstM=4'hF. Reset mid-operation discards in-flight instruction; no partial update.
//   - aluA: rrmovq(2)/OPq(6) -> valA; irmovq(3)/rmmovq(4)/mrmovq(5) -> valC; call(8)/push(A) -> -STACK_STEP;
//     ret(9)/pop(B) -> +STACK_STEP; other icodes -> 0.
//   - aluB: 4,5,6,8,9,A,B -> valB; 2,3 -> 0; others -> 0.
//   - alufun: OPq -> ifun[1:0] (0 add,1 sub,2 and,3 xor); all else add. OPq with ifun>3 is not decoded here.
//   - Arithmetic mod 2^WIDTH; sub computes aluB-aluA. Flags from the result: ZF=(valE==0), SF=valE[MSB];
//     OF add: A,B same sign and result sign differs; sub: A,B signs differ and result sign != B sign;
//     and/xor: OF=0.
//   - set_cc = (E_icode==OPq) & m_stat==AOK & W_stat==AOK & ~M_stall. cc loads on the rising edge when
//     set_cc; otherwise holds. Cnd is evaluated from the current (pre-update) cc.
//   - Cnd by ifun: 0 always;1 le (SF^OF)|ZF;2 l SF^OF;3 e ZF;4 ne ~ZF;5 ge ~(SF^OF);6 g ~(SF^OF)&~ZF;
//     7..F -> 0.
//   - e_dstE = (E_icode==2 && !Cnd) ? 4'hF : E_dstE (cmov not taken squashes write).
//   - M register, 1-cycle latency: on edge, M_stall=1 holds all M_* (stall wins over bubble);
//     else M_bubble=1 loads reset values; else loads {E_stat,E_icode,e_Cnd,e_valE,E_valA,e_dstE,E_dstM}.
//   - Exceptional E_stat (!=AOK) still propagates into M but never updates cc.
// STRUCTURE
//   - Shared package y86_pkg: icode constants (I_HALT..I_POPQ), ALU function codes, stat codes, RNONE=4'hF,
//     condition-function codes.
//   - Sub-module y86_alu #(WIDTH): combinational aluA,aluB,alufun -> valE,zf,sf,of. Operand select, cond
//     logic, cc register and M register stay in execute_pipe.
// TESTING
//   - rst=1 then release: cc=3'b100, M_icode=1, M_dstE=M_dstM=F, M_valE=0 before any clock.
//   - OPq sub, valA=1,valB=1: e_valE=0; next edge cc=3'b100; subsequent OPq add 0x7FFF..F+1 -> valE=0x8000..0,
//     cc=3'b011.
//   - cmovle after cc={0,1,0}: Cnd=1, e_dstE=E_dstE; after cc={0,0,0}: Cnd=0, e_dstE=F, M_dstE=F next edge.
//   - call valB=0x100 -> e_valE=0xF8; pop valB=0xF8 -> 0x100; WIDTH=32 build: step 4, same ops -> 0xFC/0x100.
//   - OPq with m_stat=ADR (or W_stat=HLT): valE computed, cc unchanged across edge.
//   - M_stall=1 & M_bubble=1 with new E inputs: M_* and cc hold; M_bubble alone -> M_icode=1, M_dstE=F.

Source files
------------

// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes, ALU functions,
// status codes, condition-function codes and the null register id.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alufun_e;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

endpackage

// File: rtl/execute_pipe_if.sv
// Execute-stage bundle: E-register fields and stage controls in,
// forwarding path, condition codes and M register out.
interface execute_pipe_if #(
  parameter int WIDTH = 64
);
  logic [1:0]       E_stat;
  logic [3:0]       E_icode;
  logic [3:0]       E_ifun;
  logic [WIDTH-1:0] E_valC;
  logic [WIDTH-1:0] E_valA;
  logic [WIDTH-1:0] E_valB;
  logic [3:0]       E_dstE;
  logic [3:0]       E_dstM;
  logic [1:0]       m_stat;
  logic [1:0]       W_stat;
  logic             M_stall;
  logic             M_bubble;

  logic [WIDTH-1:0] e_valE;
  logic [3:0]       e_dstE;
  logic             e_Cnd;
  logic [2:0]       cc;
  logic [1:0]       M_stat;
  logic [3:0]       M_icode;
  logic             M_Cnd;
  logic [WIDTH-1:0] M_valE;
  logic [WIDTH-1:0] M_valA;
  logic [3:0]       M_dstE;
  logic [3:0]       M_dstM;

  modport master (
    output E_stat, E_icode, E_ifun,
    output E_valC, E_valA, E_valB,
    output E_dstE, E_dstM,
    output m_stat, W_stat,
    output M_stall, M_bubble,
    input  e_valE, e_dstE, e_Cnd, cc,
    input  M_stat, M_icode, M_Cnd,
    input  M_valE, M_valA,
    input  M_dstE, M_dstM
  );

  modport slave (
    input  E_stat, E_icode, E_ifun,
    input  E_valC, E_valA, E_valB,
    input  E_dstE, E_dstM,
    input  m_stat, W_stat,
    input  M_stall, M_bubble,
    output e_valE, e_dstE, e_Cnd, cc,
    output M_stat, M_icode, M_Cnd,
    output M_valE, M_valA,
    output M_dstE, M_dstM
  );
endinterface

// File: rtl/y86_alu.sv
// Y86 ALU: add/sub/and/xor with zero, sign and overflow flags.
// Subtraction is B minus A, matching the subq operand order.
module y86_alu
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] alu_a_i,
  input  logic [WIDTH-1:0] alu_b_i,
  input  alufun_e          alufun_i,
  output logic [WIDTH-1:0] val_e_o,
  output logic             zf_o,
  output logic             sf_o,
  output logic             of_o
);

  logic sa;
  logic sb;
  logic sr;

  always_comb begin
    val_e_o = '0;
    unique case (alufun_i)
      ALU_ADD: val_e_o = alu_b_i + alu_a_i;
      ALU_SUB: val_e_o = alu_b_i - alu_a_i;
      ALU_AND: val_e_o = alu_b_i & alu_a_i;
      ALU_XOR: val_e_o = alu_b_i ^ alu_a_i;
      default: val_e_o = '0;
    endcase
  end

  assign sa = alu_a_i[WIDTH-1];
  assign sb = alu_b_i[WIDTH-1];
  assign sr = val_e_o[WIDTH-1];

  always_comb begin
    of_o = 1'b0;
    unique case (alufun_i)
      ALU_ADD: of_o = (sa == sb) && (sr != sa);
      ALU_SUB: of_o = (sa != sb) && (sr != sb);
      default: of_o = 1'b0;
    endcase
  end

  assign zf_o = (val_e_o == '0);
  assign sf_o = sr;

endmodule

// File: rtl/execute_pipe.sv
// Y86-64 execute stage: operand select, ALU, condition codes,
// cmov/jump condition and the M pipeline register.
module execute_pipe
  import y86_pkg::*;
#(
  parameter int         WIDTH      = 64,
  parameter int         STACK_STEP = WIDTH / 8,
  parameter logic [2:0] CC_RESET   = 3'b100
) (
  input  logic               clk,
  input  logic               rst,
  execute_pipe_if.slave      eif
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  alufun_e          alufun;
  logic [WIDTH-1:0] val_e;
  logic             zf;
  logic             sf;
  logic             of;
  logic             cnd;
  logic             set_cc;
  logic [3:0]       dst_e;

  logic [2:0]       cc_q;
  logic [1:0]       m_stat_q;
  logic [3:0]       m_icode_q;
  logic             m_cnd_q;
  logic [WIDTH-1:0] m_val_e_q;
  logic [WIDTH-1:0] m_val_a_q;
  logic [3:0]       m_dst_e_q;
  logic [3:0]       m_dst_m_q;

  always_comb begin
    alu_a = '0;
    unique case (1'b1)
      eif.E_icode inside {I_RRMOVQ, I_OPQ}:
        alu_a = eif.E_valA;
      eif.E_icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ}:
        alu_a = eif.E_valC;
      eif.E_icode inside {I_CALL, I_PUSHQ}:
        alu_a = '0 - STEP;
      eif.E_icode inside {I_RET, I_POPQ}:
        alu_a = STEP;
      default:
        alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    if (eif.E_icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ,
                            I_CALL, I_RET, I_PUSHQ, I_POPQ})
      alu_b = eif.E_valB;
  end

  always_comb begin
    alufun = ALU_ADD;
    if (eif.E_icode == I_OPQ)
      alufun = alufun_e'(eif.E_ifun[1:0]);
  end

  y86_alu #(.WIDTH(WIDTH)) u_alu (
    .alu_a_i  (alu_a),
    .alu_b_i  (alu_b),
    .alufun_i (alufun),
    .val_e_o  (val_e),
    .zf_o     (zf),
    .sf_o     (sf),
    .of_o     (of)
  );

  // Condition is judged against the flags before this cycle's update.
  always_comb begin
    cnd = 1'b0;
    unique case (eif.E_ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      C_L:      cnd = cc_q[1] ^ cc_q[0];
      C_E:      cnd = cc_q[2];
      C_NE:     cnd = ~cc_q[2];
      C_GE:     cnd = ~(cc_q[1] ^ cc_q[0]);
      C_G:      cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
      default:  cnd = 1'b0;
    endcase
  end

  assign set_cc = (eif.E_icode == I_OPQ) &&
                  (eif.m_stat == S_AOK) &&
                  (eif.W_stat == S_AOK) &&
                  !eif.M_stall;

  assign dst_e = (eif.E_icode == I_RRMOVQ && !cnd) ?
                 RNONE : eif.E_dstE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q      <= CC_RESET;
      m_stat_q  <= S_AOK;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_val_e_q <= '0;
      m_val_a_q <= '0;
      m_dst_e_q <= RNONE;
      m_dst_m_q <= RNONE;
    end else begin
      if (set_cc)
        cc_q <= {zf, sf, of};
      if (!eif.M_stall) begin
        if (eif.M_bubble) begin
          m_stat_q  <= S_AOK;
          m_icode_q <= I_NOP;
          m_cnd_q   <= 1'b0;
          m_val_e_q <= '0;
          m_val_a_q <= '0;
          m_dst_e_q <= RNONE;
          m_dst_m_q <= RNONE;
        end else begin
          m_stat_q  <= eif.E_stat;
          m_icode_q <= eif.E_icode;
          m_cnd_q   <= cnd;
          m_val_e_q <= val_e;
          m_val_a_q <= eif.E_valA;
          m_dst_e_q <= dst_e;
          m_dst_m_q <= eif.E_dstM;
        end
      end
    end
  end

  assign eif.e_valE  = val_e;
  assign eif.e_dstE  = dst_e;
  assign eif.e_Cnd   = cnd;
  assign eif.cc      = cc_q;
  assign eif.M_stat  = m_stat_q;
  assign eif.M_icode = m_icode_q;
  assign eif.M_Cnd   = m_cnd_q;
  assign eif.M_valE  = m_val_e_q;
  assign eif.M_valA  = m_val_a_q;
  assign eif.M_dstE  = m_dst_e_q;
  assign eif.M_dstM  = m_dst_m_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: reference model plus
// hand-computed literal checks; a 32-bit build checks stack steps.
module tb_execute_pipe;

  logic clk;
  logic rst;
  logic chk_on;
  int   n_tests;
  int   n_fail;

  execute_pipe_if #(.WIDTH(64)) eif ();
  execute_pipe_if #(.WIDTH(32)) eif32 ();

  execute_pipe #(.WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .eif (eif)
  );

  execute_pipe #(.WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .eif (eif32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Reference model
  function automatic logic [63:0] f_valE(
      input logic [3:0] ic, input logic [3:0] fn,
      input logic [63:0] a, input logic [63:0] b,
      input logic [63:0] c);
    case (ic)
      4'h2:       return a;
      4'h3:       return c;
      4'h4, 4'h5: return b + c;
      4'h6:
        case (fn)
          4'h0:    return b + a;
          4'h1:    return b - a;
          4'h2:    return b & a;
          4'h3:    return b ^ a;
          default: return 64'h0;
        endcase
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default:    return 64'h0;
    endcase
  endfunction

  function automatic logic [2:0] f_flags(
      input logic [3:0] fn,
      input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic signed [64:0] wide;
    logic o;
    r = f_valE(4'h6, fn, a, b, 64'h0);
    wide = '0;
    o = 1'b0;
    if (fn == 4'h0) begin
      wide = $signed({a[63], a}) + $signed({b[63], b});
      o = (wide[64] != wide[63]);
    end else if (fn == 4'h1) begin
      wide = $signed({b[63], b}) - $signed({a[63], a});
      o = (wide[64] != wide[63]);
    end
    return {r == 64'h0, r[63], o};
  endfunction

  function automatic logic f_cnd(input logic [3:0] fn,
                                 input logic [2:0] c);
    logic z, s, o, lt;
    z = c[2];
    s = c[1];
    o = c[0];
    lt = (s != o);
    case (fn)
      4'h0:    return 1'b1;
      4'h1:    return lt || z;
      4'h2:    return lt;
      4'h3:    return z;
      4'h4:    return !z;
      4'h5:    return !lt;
      4'h6:    return !lt && !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] f_dstE(input logic [3:0] ic,
                                        input logic [3:0] fn,
                                        input logic [3:0] d,
                                        input logic [2:0] c);
    if (ic == 4'h2 && !f_cnd(fn, c))
      return 4'hF;
    return d;
  endfunction

  logic [2:0]  mcc;
  logic [1:0]  mstat;
  logic [3:0]  micode;
  logic        mcnd;
  logic [63:0] mvalE;
  logic [63:0] mvalA;
  logic [3:0]  mdstE;
  logic [3:0]  mdstM;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcc    <= 3'b100;
      mstat  <= 2'd0;
      micode <= 4'h1;
      mcnd   <= 1'b0;
      mvalE  <= 64'h0;
      mvalA  <= 64'h0;
      mdstE  <= 4'hF;
      mdstM  <= 4'hF;
    end else begin
      if (eif.E_icode == 4'h6 && eif.m_stat == 2'd0 &&
          eif.W_stat == 2'd0 && !eif.M_stall)
        mcc <= f_flags(eif.E_ifun, eif.E_valA, eif.E_valB);
      if (!eif.M_stall) begin
        if (eif.M_bubble) begin
          mstat  <= 2'd0;
          micode <= 4'h1;
          mcnd   <= 1'b0;
          mvalE  <= 64'h0;
          mvalA  <= 64'h0;
          mdstE  <= 4'hF;
          mdstM  <= 4'hF;
        end else begin
          mstat  <= eif.E_stat;
          micode <= eif.E_icode;
          mcnd   <= f_cnd(eif.E_ifun, mcc);
          mvalE  <= f_valE(eif.E_icode, eif.E_ifun,
                           eif.E_valA, eif.E_valB, eif.E_valC);
          mvalA  <= eif.E_valA;
          mdstE  <= f_dstE(eif.E_icode, eif.E_ifun,
                           eif.E_dstE, mcc);
          mdstM  <= eif.E_dstM;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("m.e_valE", eif.e_valE,
          f_valE(eif.E_icode, eif.E_ifun,
                 eif.E_valA, eif.E_valB, eif.E_valC));
      chk("m.e_Cnd", 64'(eif.e_Cnd),
          64'(f_cnd(eif.E_ifun, mcc)));
      chk("m.e_dstE", 64'(eif.e_dstE),
          64'(f_dstE(eif.E_icode, eif.E_ifun, eif.E_dstE, mcc)));
      chk("m.cc", 64'(eif.cc), 64'(mcc));
      chk("m.M_stat", 64'(eif.M_stat), 64'(mstat));
      chk("m.M_icode", 64'(eif.M_icode), 64'(micode));
      chk("m.M_Cnd", 64'(eif.M_Cnd), 64'(mcnd));
      chk("m.M_valE", eif.M_valE, mvalE);
      chk("m.M_valA", eif.M_valA, mvalA);
      chk("m.M_dstE", 64'(eif.M_dstE), 64'(mdstE));
      chk("m.M_dstM", 64'(eif.M_dstM), 64'(mdstM));
    end
  end

  task automatic drv(input logic [3:0] ic, input logic [3:0] fn,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] c, input logic [3:0] de);
    eif.E_stat   = 2'd0;
    eif.E_icode  = ic;
    eif.E_ifun   = fn;
    eif.E_valA   = a;
    eif.E_valB   = b;
    eif.E_valC   = c;
    eif.E_dstE   = de;
    eif.E_dstM   = 4'hF;
    eif.m_stat   = 2'd0;
    eif.W_stat   = 2'd0;
    eif.M_stall  = 1'b0;
    eif.M_bubble = 1'b0;
  endtask

  task automatic drv32(input logic [3:0] ic,
                       input logic [31:0] b);
    eif32.E_stat   = 2'd0;
    eif32.E_icode  = ic;
    eif32.E_ifun   = 4'h0;
    eif32.E_valA   = 32'h0;
    eif32.E_valB   = b;
    eif32.E_valC   = 32'h0;
    eif32.E_dstE   = 4'h4;
    eif32.E_dstM   = 4'hF;
    eif32.m_stat   = 2'd0;
    eif32.W_stat   = 2'd0;
    eif32.M_stall  = 1'b0;
    eif32.M_bubble = 1'b0;
  endtask

  task automatic nxt;
    @(negedge clk);
    #1;
  endtask

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_on  = 1'b0;
    rst     = 1'b0;
    drv(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    drv32(4'h1, 32'h0);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst.cc", 64'(eif.cc), 64'h4);
    chk("rst.M_icode", 64'(eif.M_icode), 64'h1);
    chk("rst.M_stat", 64'(eif.M_stat), 64'h0);
    chk("rst.M_Cnd", 64'(eif.M_Cnd), 64'h0);
    chk("rst.M_dstE", 64'(eif.M_dstE), 64'hF);
    chk("rst.M_dstM", 64'(eif.M_dstM), 64'hF);
    chk("rst.M_valE", eif.M_valE, 64'h0);
    chk("rst.M_valA", eif.M_valA, 64'h0);
    chk_on = 1'b1;

    drv(4'h6, 4'h1, 64'd1, 64'd1, 64'h0, 4'h3);
    #1;
    chk("sub.valE", eif.e_valE, 64'h0);
    edge1;
    chk("sub.cc", 64'(eif.cc), 64'h4);
    chk("sub.M_icode", 64'(eif.M_icode), 64'h6);
    chk("sub.M_dstE", 64'(eif.M_dstE), 64'h3);

    nxt;
    drv(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 4'h3);
    #1;
    chk("addov.valE", eif.e_valE, 64'h8000_0000_0000_0000);
    edge1;
    chk("addov.cc", 64'(eif.cc), 64'h3);

    nxt;
    drv(4'h6, 4'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0, 4'h3);
    edge1;
    chk("neg.cc", 64'(eif.cc), 64'h2);

    nxt;
    drv(4'h2, 4'h1, 64'h1234, 64'h0, 64'h0, 4'h5);
    #1;
    chk("cmovle1.Cnd", 64'(eif.e_Cnd), 64'h1);
    chk("cmovle1.dstE", 64'(eif.e_dstE), 64'h5);
    chk("cmovle1.valE", eif.e_valE, 64'h1234);
    edge1;
    chk("cmovle1.M_dstE", 64'(eif.M_dstE), 64'h5);

    nxt;
    drv(4'h6, 4'h0, 64'd1, 64'd2, 64'h0, 4'h6);
    edge1;
    chk("pos.cc", 64'(eif.cc), 64'h0);
    chk("pos.M_valE", eif.M_valE, 64'd3);

    nxt;
    drv(4'h2, 4'h1, 64'h1234, 64'h0, 64'h0, 4'h5);
    #1;
    chk("cmovle0.Cnd", 64'(eif.e_Cnd), 64'h0);
    chk("cmovle0.dstE", 64'(eif.e_dstE), 64'hF);
    edge1;
    chk("cmovle0.M_dstE", 64'(eif.M_dstE), 64'hF);
    chk("cmovle0.M_Cnd", 64'(eif.M_Cnd), 64'h0);

    nxt;
    drv(4'h8, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4);
    drv32(4'h8, 32'h100);
    #1;
    chk("call.valE", eif.e_valE, 64'hF8);
    chk("call32.valE", 64'(eif32.e_valE), 64'hFC);

    nxt;
    drv(4'hB, 4'h0, 64'h0, 64'hF8, 64'h0, 4'h4);
    drv32(4'hB, 32'hFC);
    #1;
    chk("pop.valE", eif.e_valE, 64'h100);
    chk("pop32.valE", 64'(eif32.e_valE), 64'h100);

    nxt;
    drv(4'h6, 4'h3, 64'd3, 64'd3, 64'h0, 4'h2);
    eif.m_stat = 2'd2;
    #1;
    chk("adr.valE", eif.e_valE, 64'h0);
    edge1;
    chk("adr.cc", 64'(eif.cc), 64'h0);

    nxt;
    drv(4'h6, 4'h2, 64'h0, 64'd5, 64'h0, 4'h2);
    eif.W_stat = 2'd1;
    edge1;
    chk("hlt.cc", 64'(eif.cc), 64'h0);
    chk("hlt.M_icode", 64'(eif.M_icode), 64'h6);

    nxt;
    drv(4'h6, 4'h0, 64'd2, 64'd3, 64'h0, 4'h9);
    eif.M_stall  = 1'b1;
    eif.M_bubble = 1'b1;
    edge1;
    chk("stall.cc", 64'(eif.cc), 64'h0);
    chk("stall.M_icode", 64'(eif.M_icode), 64'h6);
    chk("stall.M_dstE", 64'(eif.M_dstE), 64'h2);
    chk("stall.M_valE", eif.M_valE, 64'h0);

    nxt;
    drv(4'h3, 4'h0, 64'h0, 64'h0, 64'h55, 4'h7);
    eif.M_bubble = 1'b1;
    edge1;
    chk("bub.M_icode", 64'(eif.M_icode), 64'h1);
    chk("bub.M_dstE", 64'(eif.M_dstE), 64'hF);

    nxt;
    drv(4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    eif.E_stat = 2'd1;
    edge1;
    chk("halt.M_stat", 64'(eif.M_stat), 64'h1);
    chk("halt.M_icode", 64'(eif.M_icode), 64'h0);

    nxt;
    drv(4'h3, 4'h0, 64'h0, 64'h0, 64'h55, 4'h7);
    edge1;
    chk("irmov.M_valE", eif.M_valE, 64'h55);
    chk("irmov.M_dstE", 64'(eif.M_dstE), 64'h7);

    nxt;
    drv(4'h7, 4'h4, 64'h0, 64'h0, 64'h40, 4'hF);
    #1;
    chk("jne.Cnd", 64'(eif.e_Cnd), 64'h1);
    eif.E_ifun = 4'h9;
    #1;
    chk("jbad.Cnd", 64'(eif.e_Cnd), 64'h0);

    nxt;
    drv(4'h6, 4'h1, 64'd1, 64'd1, 64'h0, 4'h3);
    edge1;
    #1 rst = 1'b1;
    #1;
    chk("rst2.cc", 64'(eif.cc), 64'h4);
    chk("rst2.M_icode", 64'(eif.M_icode), 64'h1);
    chk("rst2.M_dstE", 64'(eif.M_dstE), 64'hF);
    rst = 1'b0;
    drv(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
    nxt;
    nxt;
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
